// File: rtl/framebuffer_writer.sv
// Pixel stream sink: clips, maps to linear address, buffers and writes
// to framebuffer memory; also sweeps the whole buffer with a clear colour.
module framebuffer_writer #(
    parameter int          H_RES       = 320,
    parameter int          V_RES       = 240,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          ADDR_W      = 17,
    parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8:0]        X_in,
    input  logic [7:0]        Y_in,
    input  logic [11:0]       Color_in,
    input  logic              writeEn_in,
    input  logic              clear_req,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [11:0]       mem_data,
    output logic              mem_wren,
    output logic              busy,
    output logic              clear_done,
    output logic [15:0]       clip_count,
    output logic [15:0]       overflow_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = ADDR_W + 12;
    localparam logic [8:0] H_LIM = 9'(H_RES);
    localparam logic [7:0] V_LIM = 8'(V_RES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {STREAM, CLEAR} state_t;

    state_t state, state_next;

    logic [ENT_W-1:0]  fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic [ADDR_W-1:0] sweep_addr;
    logic              clear_pending;

    logic [ADDR_W-1:0] pix_addr;
    logic [ENT_W-1:0]  head;
    logic              on_screen, full, empty;
    logic              push, pop, go_clear, sweep_last;
    logic              clip_inc, ovf_inc;

    // y*320 + x as two shifted copies of y
    assign pix_addr = (ADDR_W'(Y_in) << 8) + (ADDR_W'(Y_in) << 6)
                    + ADDR_W'(X_in);
    assign on_screen = (X_in < H_LIM) && (Y_in < V_LIM);

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = fifo_q[rd_ptr];

    assign pop  = (state == STREAM) && !empty && mem_ready;
    assign push = (state == STREAM) && writeEn_in && on_screen
               && (!full || pop);

    assign clip_inc = writeEn_in && !on_screen;
    assign ovf_inc  = writeEn_in && on_screen && !push;

    // Switch only when no beat is left hanging on the bus
    assign go_clear   = (state == STREAM) && clear_pending
                     && (!mem_wren || mem_ready);
    assign sweep_last = (state == CLEAR) && mem_ready
                     && (sweep_addr == LAST_ADDR);

    assign busy = clear_pending || (state == CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= STREAM;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_wren   = 1'b0;
        mem_addr   = '0;
        mem_data   = '0;
        case (state)
            STREAM: begin
                if (!empty) begin
                    mem_wren = 1'b1;
                    mem_addr = head[ENT_W-1:12];
                    mem_data = head[11:0];
                end
                if (go_clear) state_next = CLEAR;
            end
            CLEAR: begin
                mem_wren = 1'b1;
                mem_addr = sweep_addr;
                mem_data = CLEAR_COLOR;
                if (sweep_last) state_next = STREAM;
            end
            default: state_next = STREAM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= {pix_addr, Color_in};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            sweep_addr     <= '0;
            clear_pending  <= 1'b0;
            clear_done     <= 1'b0;
            clip_count     <= '0;
            overflow_count <= '0;
        end else begin
            if (go_clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
            end

            if (go_clear)
                sweep_addr <= '0;
            else if (state == CLEAR && mem_ready)
                sweep_addr <= sweep_addr + 1'b1;

            if (go_clear)
                clear_pending <= 1'b0;
            else if (state == STREAM && clear_req && !busy)
                clear_pending <= 1'b1;

            clear_done <= sweep_last;

            if (clip_inc && clip_count != 16'hFFFF)
                clip_count <= clip_count + 16'd1;
            if (ovf_inc && overflow_count != 16'hFFFF)
                overflow_count <= overflow_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer: write path, clipping, FIFO
// overflow, clear sweep and reset in the middle of a sweep.
module tb_framebuffer_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  X_in;
    logic [7:0]  Y_in;
    logic [11:0] Color_in;
    logic        writeEn_in;
    logic        clear_req;
    logic        mem_ready;
    logic [16:0] mem_addr;
    logic [11:0] mem_data;
    logic        mem_wren;
    logic        busy;
    logic        clear_done;
    logic [15:0] clip_count;
    logic [15:0] overflow_count;

    int errors = 0;
    int checks = 0;
    int cd_cnt = 0;

    framebuffer_writer dut (
        .clk(clk),
        .reset(reset),
        .X_in(X_in),
        .Y_in(Y_in),
        .Color_in(Color_in),
        .writeEn_in(writeEn_in),
        .clear_req(clear_req),
        .mem_ready(mem_ready),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_wren(mem_wren),
        .busy(busy),
        .clear_done(clear_done),
        .clip_count(clip_count),
        .overflow_count(overflow_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (clear_done) cd_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        X_in = '0; Y_in = '0; Color_in = '0;
        writeEn_in = 1'b0; clear_req = 1'b0; mem_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (mem_wren !== 1'b0 || mem_addr !== 17'd0 || mem_data !== 12'd0) begin
            errors++;
            $display("FAIL reset_mem: wren=%b addr=%0d data=%h want 0/0/0",
                     mem_wren, mem_addr, mem_data);
        end
        checks++;
        if (busy !== 1'b0 || clear_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b done=%b want 0/0", busy, clear_done);
        end
        checks++;
        if (clip_count !== 16'd0 || overflow_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts: clip=%0d ovf=%0d want 0/0",
                     clip_count, overflow_count);
        end
        #4 reset = 1'b0;
        step();
    endtask

    task automatic test_single_pixel();
        mem_ready = 1'b1;
        X_in = 9'd5; Y_in = 8'd2; Color_in = 12'hF00; writeEn_in = 1'b1;
        checks++;
        if (mem_wren !== 1'b0) begin
            errors++;
            $display("FAIL single_pre: wren=%b want 0", mem_wren);
        end
        step();
        writeEn_in = 1'b0;
        checks++;
        if (mem_wren !== 1'b1 || mem_addr !== 17'd645 || mem_data !== 12'hF00) begin
            errors++;
            $display("FAIL single_beat: wren=%b addr=%0d data=%h want 1/645/f00",
                     mem_wren, mem_addr, mem_data);
        end
        step();
        checks++;
        if (mem_wren !== 1'b0 || mem_addr !== 17'd0 || mem_data !== 12'd0) begin
            errors++;
            $display("FAIL single_after: wren=%b addr=%0d data=%h want 0/0/0",
                     mem_wren, mem_addr, mem_data);
        end
    endtask

    task automatic test_clip();
        X_in = 9'd320; Y_in = 8'd0; Color_in = 12'h123; writeEn_in = 1'b1;
        step();
        X_in = 9'd0; Y_in = 8'd240;
        step();
        writeEn_in = 1'b0;
        checks++;
        if (mem_wren !== 1'b0) begin
            errors++;
            $display("FAIL clip_wren: wren=%b want 0", mem_wren);
        end
        checks++;
        if (clip_count !== 16'd2 || overflow_count !== 16'd0) begin
            errors++;
            $display("FAIL clip_counts: clip=%0d ovf=%0d want 2/0",
                     clip_count, overflow_count);
        end
    endtask

    task automatic test_overflow();
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            X_in = 9'(10 + i); Y_in = 8'd3; Color_in = 12'(i + 1);
            writeEn_in = 1'b1;
            step();
        end
        writeEn_in = 1'b0;
        checks++;
        if (overflow_count !== 16'd2 || clip_count !== 16'd2) begin
            errors++;
            $display("FAIL ovf_count: ovf=%0d clip=%0d want 2/2",
                     overflow_count, clip_count);
        end
        step(); step();
        checks++;
        if (mem_wren !== 1'b1 || mem_addr !== 17'd970 || mem_data !== 12'h001) begin
            errors++;
            $display("FAIL ovf_hold: wren=%b addr=%0d data=%h want 1/970/001",
                     mem_wren, mem_addr, mem_data);
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_wren !== 1'b1 || mem_addr !== 17'(970 + i)
                || mem_data !== 12'(i + 1)) begin
                errors++;
                $display("FAIL ovf_drain%0d: wren=%b addr=%0d data=%h want 1/%0d/%0h",
                         i, mem_wren, mem_addr, mem_data, 970 + i, i + 1);
            end
            step();
        end
        checks++;
        if (mem_wren !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty: wren=%b want 0", mem_wren);
        end
    endtask

    task automatic test_corner();
        X_in = 9'd319; Y_in = 8'd239; Color_in = 12'h0AB; writeEn_in = 1'b1;
        step();
        writeEn_in = 1'b0;
        checks++;
        if (mem_wren !== 1'b1 || mem_addr !== 17'd76799 || mem_data !== 12'h0AB) begin
            errors++;
            $display("FAIL corner: wren=%b addr=%0d data=%h want 1/76799/0ab",
                     mem_wren, mem_addr, mem_data);
        end
        step();
    endtask

    task automatic test_clear_sweep();
        int n = 0;
        int seq_err = 0;
        int first_bad = -1;
        mem_ready = 1'b0;
        X_in = 9'd0; Y_in = 8'd10; Color_in = 12'h111; writeEn_in = 1'b1;
        step();
        X_in = 9'd1; Color_in = 12'h222;
        step();
        writeEn_in = 1'b0;
        checks++;
        if (mem_wren !== 1'b1 || mem_addr !== 17'd3200 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_pre: wren=%b addr=%0d busy=%b want 1/3200/0",
                     mem_wren, mem_addr, busy);
        end
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        checks++;
        if (busy !== 1'b1 || mem_addr !== 17'd3200 || mem_data !== 12'h111) begin
            errors++;
            $display("FAIL clr_pending: busy=%b addr=%0d data=%h want 1/3200/111",
                     busy, mem_addr, mem_data);
        end
        mem_ready = 1'b1;
        step();
        checks++;
        if (mem_wren !== 1'b1 || mem_addr !== 17'd0 || mem_data !== 12'h000
            || busy !== 1'b1) begin
            errors++;
            $display("FAIL clr_start: wren=%b addr=%0d data=%h busy=%b want 1/0/000/1",
                     mem_wren, mem_addr, mem_data, busy);
        end
        for (int cyc = 0; cyc < 77000; cyc++) begin
            if (busy !== 1'b1 || mem_wren !== 1'b1 || mem_addr !== 17'(n)
                || mem_data !== 12'h000) begin
                seq_err++;
                if (first_bad < 0) first_bad = n;
            end
            writeEn_in = 1'b0;
            if (cyc >= 100 && cyc <= 102) begin
                X_in = 9'd5; Y_in = 8'd5; writeEn_in = 1'b1;
            end else if (cyc == 200) begin
                X_in = 9'd400; Y_in = 8'd0; writeEn_in = 1'b1;
            end
            clear_req = (cyc == 300);
            step();
            n++;
            if (clear_done === 1'b1) break;
        end
        writeEn_in = 1'b0;
        clear_req = 1'b0;
        checks++;
        if (seq_err != 0) begin
            errors++;
            $display("FAIL clr_sequence: %0d bad beats, first at %0d want 0",
                     seq_err, first_bad);
        end
        checks++;
        if (n != 76800) begin
            errors++;
            $display("FAIL clr_length: beats=%0d want 76800", n);
        end
        checks++;
        if (busy !== 1'b0 || mem_wren !== 1'b0) begin
            errors++;
            $display("FAIL clr_end: busy=%b wren=%b want 0/0", busy, mem_wren);
        end
        checks++;
        if (clip_count !== 16'd3 || overflow_count !== 16'd5) begin
            errors++;
            $display("FAIL clr_counts: clip=%0d ovf=%0d want 3/5",
                     clip_count, overflow_count);
        end
        step();
        checks++;
        if (clear_done !== 1'b0 || busy !== 1'b0 || cd_cnt != 1) begin
            errors++;
            $display("FAIL clr_pulse: done=%b busy=%b pulses=%0d want 0/0/1",
                     clear_done, busy, cd_cnt);
        end
    endtask

    task automatic test_reset_mid_clear();
        int cd_before;
        mem_ready = 1'b1;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (mem_wren === 1'b1 && mem_addr === 17'd1000) break;
            step();
        end
        checks++;
        if (mem_addr !== 17'd1000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_reach: addr=%0d busy=%b want 1000/1", mem_addr, busy);
        end
        cd_before = cd_cnt;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (mem_wren !== 1'b0 || mem_addr !== 17'd0 || mem_data !== 12'd0
            || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: wren=%b addr=%0d data=%h busy=%b want 0/0/0/0",
                     mem_wren, mem_addr, mem_data, busy);
        end
        checks++;
        if (clip_count !== 16'd0 || overflow_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_counts: clip=%0d ovf=%0d want 0/0",
                     clip_count, overflow_count);
        end
        #1 reset = 1'b0;
        step();
        X_in = 9'd1; Y_in = 8'd0; Color_in = 12'hABC; writeEn_in = 1'b1;
        checks++;
        if (mem_wren !== 1'b0 || cd_cnt != cd_before) begin
            errors++;
            $display("FAIL rst_nodone: wren=%b pulses=%0d want 0/%0d",
                     mem_wren, cd_cnt, cd_before);
        end
        step();
        writeEn_in = 1'b0;
        checks++;
        if (mem_wren !== 1'b1 || mem_addr !== 17'd1 || mem_data !== 12'hABC) begin
            errors++;
            $display("FAIL rst_pixel: wren=%b addr=%0d data=%h want 1/1/abc",
                     mem_wren, mem_addr, mem_data);
        end
        step();
        checks++;
        if (mem_wren !== 1'b0) begin
            errors++;
            $display("FAIL rst_pixel_end: wren=%b want 0", mem_wren);
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_clip();
        test_overflow();
        test_corner();
        test_clear_sweep();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
